// File: rtl/rotary_quad_decoder.sv
// Quadrature rotary-encoder decoder: turns A/B Gray-code quarter-steps into a
// detent position counter with direction pulses and illegal-transition flags.
module rotary_quad_decoder #(
  parameter int COUNT_W          = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_in,
  input  logic               b_in,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               step_cw,
  output logic               step_ccw,
  output logic               illegal,
  output logic               error_sticky
);

  localparam int ACC_W = 4;
  localparam logic signed [ACC_W-1:0] ACC_LIM = ACC_W'(STEPS_PER_DETENT);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [1:0]              cur_ab;
  logic [1:0]              prev_ab;
  logic                    init;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_up;
  logic signed [ACC_W-1:0] acc_dn;
  logic [1:0]              dphase;
  logic                    is_cw;
  logic                    is_ccw;
  logic                    is_ill;

  // Position of an {a,b} value around the CW cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  function automatic logic [COUNT_W-1:0] cnt_inc(input logic [COUNT_W-1:0] c);
    if (WRAP != 0)         cnt_inc = c + COUNT_W'(1);
    else if (c == CNT_MAX) cnt_inc = c;
    else                   cnt_inc = c + COUNT_W'(1);
  endfunction

  function automatic logic [COUNT_W-1:0] cnt_dec(input logic [COUNT_W-1:0] c);
    if (WRAP != 0)              cnt_dec = c - COUNT_W'(1);
    else if (c == '0)           cnt_dec = c;
    else                        cnt_dec = c - COUNT_W'(1);
  endfunction

  assign cur_ab = {a_in, b_in};
  assign dphase = phase(cur_ab) - phase(prev_ab);
  assign is_cw  = (dphase == 2'd1);
  assign is_ccw = (dphase == 2'd3);
  assign is_ill = (dphase == 2'd2);
  assign acc_up = acc + 4'sd1;
  assign acc_dn = acc - 4'sd1;

  // Decode stage: (prev_ab, cur_ab) -> registered count, pulses and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab      <= 2'b00;
      init         <= 1'b0;
      acc          <= '0;
      count        <= '0;
      step_cw      <= 1'b0;
      step_ccw     <= 1'b0;
      illegal      <= 1'b0;
      error_sticky <= 1'b0;
    end else begin
      prev_ab  <= cur_ab;
      init     <= 1'b1;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      illegal  <= 1'b0;
      if (clr) begin
        count        <= '0;
        acc          <= '0;
        error_sticky <= 1'b0;
      end else if (init) begin
        if (is_ill) begin
          illegal      <= 1'b1;
          error_sticky <= 1'b1;
          acc          <= '0;
        end else if (is_cw) begin
          if (acc_up == ACC_LIM) begin
            acc     <= '0;
            step_cw <= 1'b1;
            count   <= cnt_inc(count);
          end else begin
            acc <= acc_up;
          end
        end else if (is_ccw) begin
          if (acc_dn == -ACC_LIM) begin
            acc      <= '0;
            step_ccw <= 1'b1;
            count    <= cnt_dec(count);
          end else begin
            acc <= acc_dn;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Bench for rotary_quad_decoder: a wrapping and a saturating instance share the
// same stimulus and are compared every edge against a phase-arithmetic model.
module tb_rotary_quad_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] count_w, count_s;
  logic       cw_w, ccw_w, ill_w, err_w;
  logic       cw_s, ccw_s, ill_s, err_s;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  int m_cnt_w, m_cnt_s, m_acc;
  bit m_init, m_err, m_cw, m_ccw, m_ill;
  logic [1:0] m_prev;

  // pulse tallies for directed segments
  int t_cw_w, t_ccw_w, t_cw_s, t_ccw_s, t_ill;

  rotary_quad_decoder #(.COUNT_W(8), .STEPS_PER_DETENT(4), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr(clr),
    .count(count_w), .step_cw(cw_w), .step_ccw(ccw_w), .illegal(ill_w),
    .error_sticky(err_w));

  rotary_quad_decoder #(.COUNT_W(8), .STEPS_PER_DETENT(4), .WRAP(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr(clr),
    .count(count_s), .step_cw(cw_s), .step_ccw(ccw_s), .illegal(ill_s),
    .error_sticky(err_s));

  always #5 clk = ~clk;

  function automatic int ph(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt_w = 0; m_cnt_s = 0; m_acc = 0; m_init = 0; m_err = 0;
    m_cw = 0; m_ccw = 0; m_ill = 0; m_prev = 2'b00;
  endtask

  task automatic model_edge(input logic [1:0] ab, input bit c);
    int d;
    m_cw = 0; m_ccw = 0; m_ill = 0;
    if (c) begin
      m_cnt_w = 0; m_cnt_s = 0; m_acc = 0; m_err = 0;
    end else if (m_init && ab != m_prev) begin
      d = (ph(ab) - ph(m_prev) + 4) % 4;
      if (d == 2) begin
        m_ill = 1; m_err = 1; m_acc = 0;
      end else if (d == 1) begin
        m_acc++;
        if (m_acc == 4) begin
          m_acc = 0; m_cw = 1;
          m_cnt_w = (m_cnt_w + 1) % 256;
          m_cnt_s = (m_cnt_s < 255) ? m_cnt_s + 1 : 255;
        end
      end else begin
        m_acc--;
        if (m_acc == -4) begin
          m_acc = 0; m_ccw = 1;
          m_cnt_w = (m_cnt_w + 255) % 256;
          m_cnt_s = (m_cnt_s > 0) ? m_cnt_s - 1 : 0;
        end
      end
    end
    m_prev = ab;
    m_init = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count_w"}, int'(count_w), m_cnt_w);
    chk({tag, ".count_s"}, int'(count_s), m_cnt_s);
    chk({tag, ".cw"},      int'(cw_w),  int'(m_cw));
    chk({tag, ".ccw"},     int'(ccw_w), int'(m_ccw));
    chk({tag, ".cw_s"},    int'(cw_s),  int'(m_cw));
    chk({tag, ".ccw_s"},   int'(ccw_s), int'(m_ccw));
    chk({tag, ".ill"},     int'(ill_w), int'(m_ill));
    chk({tag, ".ill_s"},   int'(ill_s), int'(m_ill));
    chk({tag, ".err"},     int'(err_w), int'(m_err));
    chk({tag, ".err_s"},   int'(err_s), int'(m_err));
    chk({tag, ".excl"},    int'(cw_w & ccw_w), 0);
  endtask

  task automatic cyc(input string tag, input logic [1:0] ab, input bit c = 0);
    @(negedge clk);
    a_in = ab[1]; b_in = ab[0]; clr = c;
    @(posedge clk);
    model_edge(ab, c);
    #1;
    check_all(tag);
    t_cw_w += int'(cw_w); t_ccw_w += int'(ccw_w);
    t_cw_s += int'(cw_s); t_ccw_s += int'(ccw_s);
    t_ill  += int'(ill_w);
  endtask

  task automatic seq(input string tag, input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) cyc(tag, ab);
  endtask

  task automatic tally_clear();
    t_cw_w = 0; t_ccw_w = 0; t_cw_s = 0; t_ccw_s = 0; t_ill = 0;
  endtask

  // Asynchronous reset pulse between edges, released with the given {a,b}.
  task automatic async_reset(input string tag, input logic [1:0] ab);
    @(negedge clk);
    #2 rst_n = 1'b0;
    a_in = ab[1]; b_in = ab[0]; clr = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int p;
    logic [1:0] nab;
    model_reset();
    tally_clear();
    // reset state
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seq("init", 2'b00, 3);

    // full CW detent, 4 clocks per phase
    tally_clear();
    seq("cw", 2'b10, 4); seq("cw", 2'b11, 4); seq("cw", 2'b01, 4);
    seq("cw", 2'b00, 4);
    chk("cw.count", int'(count_w), 1);
    chk("cw.pulses", t_cw_w, 1);
    chk("cw.no_ccw", t_ccw_w, 0);

    // full CCW detent from 0: wraps vs saturates
    cyc("clr0", 2'b00, 1);
    tally_clear();
    seq("ccw", 2'b01, 2); seq("ccw", 2'b11, 2); seq("ccw", 2'b10, 2);
    seq("ccw", 2'b00, 2);
    chk("ccw.count_w", int'(count_w), 255);
    chk("ccw.count_s", int'(count_s), 0);
    chk("ccw.pulse_w", t_ccw_w, 1);
    chk("ccw.pulse_s", t_ccw_s, 1);

    // jitter back and forth then complete
    cyc("clr1", 2'b00, 1);
    tally_clear();
    cyc("jit", 2'b10); cyc("jit", 2'b00); cyc("jit", 2'b10);
    cyc("jit", 2'b11); cyc("jit", 2'b01); cyc("jit", 2'b00);
    chk("jit.pulses", t_cw_w, 1);
    chk("jit.count", int'(count_w), 1);

    // illegal transition then clear
    tally_clear();
    cyc("ill", 2'b11);
    chk("ill.pulse", int'(ill_w), 1);
    chk("ill.sticky", int'(err_w), 1);
    chk("ill.count", int'(count_w), 1);
    seq("ill_hold", 2'b11, 2);
    chk("ill.one_cycle", t_ill, 1);
    chk("ill.sticky_hold", int'(err_w), 1);
    cyc("ill_clr", 2'b11, 1);
    chk("clr.sticky", int'(err_w), 0);
    chk("clr.count", int'(count_w), 0);

    // reset mid-rotation, release on 01
    seq("pre", 2'b00, 2);
    cyc("clr2", 2'b00, 1);
    cyc("mid", 2'b10); cyc("mid", 2'b11); cyc("mid", 2'b01);
    async_reset("midrst", 2'b01);
    tally_clear();
    cyc("resume", 2'b01);
    cyc("resume", 2'b00);
    chk("resume.no_step", t_cw_w + t_ccw_w, 0);
    cyc("resume", 2'b10); cyc("resume", 2'b11);
    chk("resume.acc3", t_cw_w, 0);
    cyc("resume", 2'b01);
    chk("resume.step", t_cw_w, 1);
    chk("resume.count", int'(count_w), 1);

    // 255 CW detents with saturation, then one more
    cyc("clr3", 2'b01, 1);
    cyc("clr3", 2'b00, 1);
    tally_clear();
    for (int d = 0; d < 255; d++) begin
      cyc("sat", 2'b10); cyc("sat", 2'b11); cyc("sat", 2'b01); cyc("sat", 2'b00);
    end
    chk("sat.count_s", int'(count_s), 255);
    chk("sat.pulses_s", t_cw_s, 255);
    chk("sat.count_w", int'(count_w), 255);
    cyc("sat", 2'b10); cyc("sat", 2'b11); cyc("sat", 2'b01); cyc("sat", 2'b00);
    chk("sat.hold", int'(count_s), 255);
    chk("sat.wrap", int'(count_w), 0);
    chk("sat.pulses_more", t_cw_s, 256);

    // randomized walk with holds, jitter, illegal jumps and occasional clear
    p = ph({a_in, b_in});
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 6)        nab = ab_of(p);
      else if (r < 12)  nab = ab_of(p + 1);
      else if (r < 18)  nab = ab_of(p + 3);
      else              nab = 2'($urandom_range(0, 3));
      p = ph(nab);
      if (i == 700) async_reset("rnd", nab);
      cyc("rnd", nab, ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rotary_quad_decoder.md
ROTARY_QUAD_DECODER -- requirements
Module: rotary_quad_decoder

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 8, meaning position counter width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter STEPS_PER_DETENT, default 4, meaning quarter-steps per reported detent (legal values 1, 2, 4).
REQ-003 The block SHALL have parameter WRAP, default 1, meaning 1 = count wraps modulo 2^COUNT_W, 0 = count saturates at 0 and 2^COUNT_W-1.
REQ-004 The block SHALL have port clk  input  1  single clock, 50MHz, all state on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port a_in  input  1  encoder channel A, already synchronised and debounced upstream.
REQ-007 The block SHALL have port b_in  input  1  encoder channel B, already synchronised and debounced upstream.
REQ-008 The block SHALL have port clr  input  1  synchronous clear of count, accumulator and error_sticky.
REQ-009 The block SHALL have port count  output  COUNT_W  current detent position, registered.
REQ-010 The block SHALL have port step_cw  output  1  one-cycle pulse per clockwise detent.
REQ-011 The block SHALL have port step_ccw  output  1  one-cycle pulse per counter-clockwise detent.
REQ-012 The block SHALL have port illegal  output  1  one-cycle pulse on a two-bit input transition.
REQ-013 The block SHALL have port error_sticky  output  1  set by any illegal transition, held until clr or reset.

Function
REQ-014 The block SHALL register {a_in,b_in} each clock as prev_ab and decode the pair (prev_ab, {a_in,b_in}) combinationally; all outputs SHALL be registered, so a response appears one clock edge after the new input value is first sampled.
REQ-015 The block SHALL hold an init flag, cleared by reset; the first edge after reset SHALL load prev_ab and set the flag without decoding.
REQ-016 Clockwise quarter-steps SHALL be {a,b} transitions 00->10, 10->11, 11->01, 01->00; counter-clockwise SHALL be their reverses.
REQ-017 No change in {a,b} SHALL leave all state unchanged and outputs step_cw, step_ccw, illegal at 0.
REQ-018 A signed quarter-step accumulator (range -STEPS_PER_DETENT..+STEPS_PER_DETENT) SHALL increment on CW and decrement on CCW quarter-steps.
REQ-019 When the accumulator would reach +STEPS_PER_DETENT, the block SHALL instead clear it to 0, pulse step_cw and increment count in the same edge; symmetrically for -STEPS_PER_DETENT with step_ccw and decrement.
REQ-020 A transition where both bits change SHALL pulse illegal, set error_sticky, clear the accumulator to 0 and leave count unchanged.
REQ-021 With WRAP=1, count SHALL wrap 2^COUNT_W-1 -> 0 on CW and 0 -> 2^COUNT_W-1 on CCW.
REQ-022 With WRAP=0, count SHALL hold at its limit; the step pulse SHALL still assert.
REQ-023 clr=1 SHALL zero count, accumulator and error_sticky at the edge and suppress step_cw, step_ccw, illegal that cycle; prev_ab SHALL still update.
REQ-024 step_cw and step_ccw SHALL never be asserted in the same cycle.

Reset
REQ-025 rst_n=0 SHALL asynchronously force count=0, step_cw=0, step_ccw=0, illegal=0, error_sticky=0, accumulator=0, init flag=0, prev_ab=00.
REQ-026 Deassertion of rst_n mid-rotation SHALL resume per REQ-015 with no spurious pulse, regardless of the {a_in,b_in} value.

Verification
REQ-027 Bench: reset, {a,b}=00, apply 10,11,01,00 (4 clks each) -> one step_cw pulse one edge after 00 is sampled, count=1, no step_ccw.
REQ-028 Bench: from count=0, one full CCW cycle 00,01,11,10,00 -> step_ccw pulse, count=255 (WRAP=1); with WRAP=0 -> count=0, step_ccw still pulses.
REQ-029 Bench: 00->10->00->10->11->01->00 (jitter) -> exactly one step_cw, count=1.
REQ-030 Bench: 00->11 -> illegal pulse one cycle, error_sticky=1, count unchanged; then clr=1 one clock -> error_sticky=0, count=0.
REQ-031 Bench: assert rst_n=0 asynchronously after 3 CW quarter-steps, release with {a,b}=01 -> all outputs 0, next 01->00 produces no step (accumulator=-... reads 1 quarter-step CW only).
REQ-032 Bench: 255 CW detents from 0 with WRAP=0 -> count holds 255, 255 step_cw pulses total.
